// File: rtl/mempool_pkg.sv
// Shared MemPool word, address and byte-enable types.
// Used by the tile-local TCDM bank arbitration logic.
package mempool_pkg;

    localparam int unsigned AddrWidth = 10;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned BeWidth   = DataWidth / 8;

    typedef logic [AddrWidth-1:0] tcdm_addr_t;
    typedef logic [DataWidth-1:0] data_t;
    typedef logic [BeWidth-1:0]   be_t;

endpackage

// File: rtl/tcdm_rr_pick.sv
// Pointer-rotated first-one search.
// Scans req starting at ptr and wrapping modulo NumIn.
module tcdm_rr_pick #(
    parameter int NumIn = 4,
    localparam int IdxW = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic [NumIn-1:0] req,
    input  logic [IdxW-1:0]  ptr,
    output logic [IdxW-1:0]  idx,
    output logic             valid
);

    int k;

    // Walk from the farthest offset down so the nearest hit wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        k     = 0;
        for (int i = NumIn - 1; i >= 0; i--) begin
            k = int'(ptr) + i;
            if (k >= NumIn) k = k - NumIn;
            if (req[k]) begin
                idx   = IdxW'(k);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tcdm_bank_arbiter.sv
// Lock-stable round-robin arbiter for one TCDM bank port.
// Routes each one-cycle-latency read response back to its requester.
module tcdm_bank_arbiter
    import mempool_pkg::*;
#(
    parameter int NumIn       = 4,
    parameter bit WriteRespOn = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumIn-1:0]       req_i,
    input  tcdm_addr_t [NumIn-1:0] addr_i,
    input  logic [NumIn-1:0]       wen_i,
    input  data_t [NumIn-1:0]      wdata_i,
    input  be_t [NumIn-1:0]        be_i,
    output logic [NumIn-1:0]       gnt_o,
    output logic [NumIn-1:0]       vld_o,
    output data_t [NumIn-1:0]      rdata_o,
    output logic                   mem_req_o,
    output tcdm_addr_t             mem_addr_o,
    output logic                   mem_wen_o,
    output data_t                  mem_wdata_o,
    output be_t                    mem_be_o,
    input  logic                   mem_gnt_i,
    input  data_t                  mem_rdata_i
);

    localparam int IdxW = (NumIn > 1) ? $clog2(NumIn) : 1;

    logic [IdxW-1:0] rr_q;
    logic            lock_q;
    logic [IdxW-1:0] lock_idx_q;
    logic            vld_q;
    logic [IdxW-1:0] rsp_idx_q;

    logic [IdxW-1:0] pick_idx;
    logic            pick_vld;
    logic [IdxW-1:0] sel;
    logic            xfer;

    tcdm_rr_pick #(
        .NumIn(NumIn)
    ) i_pick (
        .req  (req_i),
        .ptr  (rr_q),
        .idx  (pick_idx),
        .valid(pick_vld)
    );

    // A stalled selection stays put until the bank accepts it.
    assign sel       = lock_q ? lock_idx_q : pick_idx;
    assign mem_req_o = |req_i;
    assign xfer      = mem_req_o && mem_gnt_i;

    always_comb begin
        mem_addr_o  = addr_i[0];
        mem_wen_o   = wen_i[0];
        mem_wdata_o = wdata_i[0];
        mem_be_o    = be_i[0];
        for (int i = 1; i < NumIn; i++) begin
            if (sel == IdxW'(i)) begin
                mem_addr_o  = addr_i[i];
                mem_wen_o   = wen_i[i];
                mem_wdata_o = wdata_i[i];
                mem_be_o    = be_i[i];
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        vld_o = '0;
        for (int i = 0; i < NumIn; i++) begin
            gnt_o[i]   = (sel == IdxW'(i)) && mem_gnt_i && req_i[i];
            vld_o[i]   = (rsp_idx_q == IdxW'(i)) && vld_q;
            rdata_o[i] = mem_rdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            vld_q      <= 1'b0;
            rsp_idx_q  <= '0;
        end else begin
            vld_q <= 1'b0;
            if (xfer) begin
                rr_q      <= (sel == IdxW'(NumIn - 1)) ? '0 : sel + IdxW'(1);
                lock_q    <= 1'b0;
                vld_q     <= !mem_wen_o || WriteRespOn;
                rsp_idx_q <= sel;
            end else if (mem_req_o) begin
                lock_q     <= 1'b1;
                lock_idx_q <= sel;
            end
        end
    end

    // Requesters must hold their request while the bank stalls them.
    a_lock_hold : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        lock_q |-> req_i[lock_idx_q]
    );

    logic unused_pick_vld;
    assign unused_pick_vld = pick_vld;

endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// Randomized bench for tcdm_bank_arbiter against a behavioural model.
// Two instances: 4 inputs without write responses, 3 inputs with them.
module tb_tcdm_bank_arbiter;
    import mempool_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_ni;

    logic [3:0]       req_a, wen_a, gnt_a, vld_a;
    tcdm_addr_t [3:0] addr_a;
    data_t [3:0]      wdata_a, rdata_a;
    be_t [3:0]        be_a;
    logic             mem_req_a, mem_wen_a, mem_gnt_a;
    tcdm_addr_t       mem_addr_a;
    data_t            mem_wdata_a, mem_rdata_a;
    be_t              mem_be_a;

    logic [2:0]       req_b, wen_b, gnt_b, vld_b;
    tcdm_addr_t [2:0] addr_b;
    data_t [2:0]      wdata_b, rdata_b;
    be_t [2:0]        be_b;
    logic             mem_req_b, mem_wen_b, mem_gnt_b;
    tcdm_addr_t       mem_addr_b;
    data_t            mem_wdata_b, mem_rdata_b;
    be_t              mem_be_b;

    tcdm_bank_arbiter #(.NumIn(4), .WriteRespOn(1'b0)) u_a (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_i(req_a), .addr_i(addr_a), .wen_i(wen_a),
        .wdata_i(wdata_a), .be_i(be_a),
        .gnt_o(gnt_a), .vld_o(vld_a), .rdata_o(rdata_a),
        .mem_req_o(mem_req_a), .mem_addr_o(mem_addr_a),
        .mem_wen_o(mem_wen_a), .mem_wdata_o(mem_wdata_a),
        .mem_be_o(mem_be_a), .mem_gnt_i(mem_gnt_a),
        .mem_rdata_i(mem_rdata_a)
    );

    tcdm_bank_arbiter #(.NumIn(3), .WriteRespOn(1'b1)) u_b (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_i(req_b), .addr_i(addr_b), .wen_i(wen_b),
        .wdata_i(wdata_b), .be_i(be_b),
        .gnt_o(gnt_b), .vld_o(vld_b), .rdata_o(rdata_b),
        .mem_req_o(mem_req_b), .mem_addr_o(mem_addr_b),
        .mem_wen_o(mem_wen_b), .mem_wdata_o(mem_wdata_b),
        .mem_be_o(mem_be_b), .mem_gnt_i(mem_gnt_b),
        .mem_rdata_i(mem_rdata_b)
    );

    int checks   = 0;
    int failures = 0;

    int  nin[2]   = '{4, 3};
    bit  wresp[2] = '{1'b0, 1'b1};

    bit         t_req[2][4];
    bit         t_wen[2][4];
    tcdm_addr_t t_addr[2][4];
    data_t      t_wdata[2][4];
    be_t        t_be[2][4];
    bit         t_gnt[2];
    data_t      t_rdata[2];
    bit         held[2][4];

    // Model state: next-priority index, pending stalled requester, response.
    int m_ptr[2], m_lock[2], m_li[2], m_vld[2], m_rsp[2];

    logic [3:0] last_gnt[2], last_vld[2];
    tcdm_addr_t last_addr[2];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void pick(input int d, output int sel, output bit any);
        int  n;
        bit  found;
        n     = nin[d];
        sel   = 0;
        any   = 1'b0;
        found = 1'b0;
        for (int k = 0; k < n; k++) any |= t_req[d][k];
        if (m_lock[d] != 0) begin
            sel = m_li[d];
        end else begin
            for (int i = 0; i < n; i++) begin
                int k;
                k = (m_ptr[d] + i) % n;
                if (!found && t_req[d][k]) begin
                    sel   = k;
                    found = 1'b1;
                end
            end
        end
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ptr[d] = 0; m_lock[d] = 0; m_li[d] = 0;
            m_vld[d] = 0; m_rsp[d] = 0;
            for (int k = 0; k < 4; k++) held[d][k] = 1'b0;
        end
    endtask

    task automatic drive();
        for (int k = 0; k < 4; k++) begin
            req_a[k] = t_req[0][k]; wen_a[k] = t_wen[0][k];
            addr_a[k] = t_addr[0][k]; wdata_a[k] = t_wdata[0][k];
            be_a[k] = t_be[0][k];
        end
        for (int k = 0; k < 3; k++) begin
            req_b[k] = t_req[1][k]; wen_b[k] = t_wen[1][k];
            addr_b[k] = t_addr[1][k]; wdata_b[k] = t_wdata[1][k];
            be_b[k] = t_be[1][k];
        end
        mem_gnt_a = t_gnt[0]; mem_rdata_a = t_rdata[0];
        mem_gnt_b = t_gnt[1]; mem_rdata_b = t_rdata[1];
    endtask

    task automatic check_dut(input int d);
        int sel, rk;
        bit any;
        string p;
        logic [3:0] og, ov, eg, ev;
        logic oreq, owen;
        tcdm_addr_t oaddr;
        data_t owd, ord;
        be_t obe;
        pick(d, sel, any);
        rk = $urandom_range(0, nin[d] - 1);
        if (d == 0) begin
            og = gnt_a; ov = vld_a; oreq = mem_req_a; oaddr = mem_addr_a;
            owen = mem_wen_a; owd = mem_wdata_a; obe = mem_be_a;
            ord = rdata_a[rk];
            p = "a";
        end else begin
            og = {1'b0, gnt_b}; ov = {1'b0, vld_b}; oreq = mem_req_b;
            oaddr = mem_addr_b; owen = mem_wen_b; owd = mem_wdata_b;
            obe = mem_be_b; ord = rdata_b[rk];
            p = "b";
        end
        eg = (any && t_gnt[d]) ? 4'(1 << sel) : 4'd0;
        ev = (m_vld[d] != 0) ? 4'(1 << m_rsp[d]) : 4'd0;
        chk({p, "_gnt"}, 64'(og), 64'(eg));
        chk({p, "_mem_req"}, 64'(oreq), 64'(any));
        chk({p, "_mem_addr"}, 64'(oaddr), 64'(t_addr[d][sel]));
        chk({p, "_mem_wen"}, 64'(owen), 64'(t_wen[d][sel]));
        chk({p, "_mem_wdata"}, 64'(owd), 64'(t_wdata[d][sel]));
        chk({p, "_mem_be"}, 64'(obe), 64'(t_be[d][sel]));
        chk({p, "_vld"}, 64'(ov), 64'(ev));
        chk({p, "_rdata"}, 64'(ord), 64'(t_rdata[d]));
        last_gnt[d]  = og;
        last_vld[d]  = ov;
        last_addr[d] = oaddr;
    endtask

    task automatic update(input int d);
        int sel;
        bit any, xfer;
        if (!rst_ni) begin
            model_reset();
            return;
        end
        pick(d, sel, any);
        xfer = any && t_gnt[d];
        for (int k = 0; k < 4; k++)
            held[d][k] = t_req[d][k] && !(xfer && sel == k);
        if (xfer) begin
            m_ptr[d]  = (sel + 1) % nin[d];
            m_lock[d] = 0;
            m_vld[d]  = (!t_wen[d][sel] || wresp[d]) ? 1 : 0;
            m_rsp[d]  = sel;
        end else begin
            m_vld[d] = 0;
            if (any) begin
                m_lock[d] = 1;
                m_li[d]   = sel;
            end
        end
    endtask

    // Inputs change only just after a falling edge.
    task automatic step();
        drive();
        #1;
        check_dut(0);
        check_dut(1);
        @(posedge clk);
        update(0);
        update(1);
        @(negedge clk);
    endtask

    task automatic clr();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) begin
                t_req[d][k] = 1'b0; t_wen[d][k] = 1'b0;
                t_addr[d][k] = tcdm_addr_t'(k);
                t_wdata[d][k] = data_t'(32'hA000 + k);
                t_be[d][k] = be_t'(4'hF);
            end
            t_gnt[d]   = 1'b1;
            t_rdata[d] = data_t'($urandom);
        end
    endtask

    task automatic rand_inputs();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) begin
                if (k >= nin[d]) begin
                    t_req[d][k] = 1'b0;
                end else if (!held[d][k]) begin
                    t_req[d][k]   = 1'($urandom_range(0, 1));
                    t_wen[d][k]   = 1'($urandom_range(0, 1));
                    t_addr[d][k]  = tcdm_addr_t'($urandom);
                    t_wdata[d][k] = data_t'($urandom);
                    t_be[d][k]    = be_t'($urandom);
                end
            end
            t_gnt[d]   = ($urandom_range(0, 3) != 0);
            t_rdata[d] = data_t'($urandom);
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        model_reset();
        clr();
        drive();
        @(negedge clk);
        step();
        step();
        rst_ni = 1'b1;

        // Fairness from a fresh pointer.
        clr();
        for (int k = 0; k < 4; k++) begin
            t_req[0][k] = 1'b1;
            t_addr[0][k] = tcdm_addr_t'(10'h20 + k);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("fair_gnt%0d", i), 64'(last_gnt[0]), 64'(1 << (i % 4)));
            if (i > 0)
                chk($sformatf("fair_vld%0d", i), 64'(last_vld[0]),
                    64'(1 << ((i - 1) % 4)));
        end

        // Single read by requester 2.
        clr();
        t_req[0][2] = 1'b1;
        t_addr[0][2] = tcdm_addr_t'(10'h10);
        step();
        chk("single_gnt", 64'(last_gnt[0]), 64'h4);
        clr();
        step();
        chk("single_vld", 64'(last_vld[0]), 64'h4);

        // Stall lock: late requester 0 must not preempt requester 1.
        clr();
        t_gnt[0] = 1'b0;
        t_req[0][1] = 1'b1;
        t_addr[0][1] = tcdm_addr_t'(10'h155);
        t_addr[0][0] = tcdm_addr_t'(10'h0AA);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) t_req[0][0] = 1'b1;
            step();
            chk($sformatf("stall_addr%0d", i), 64'(last_addr[0]), 64'h155);
            chk($sformatf("stall_gnt%0d", i), 64'(last_gnt[0]), 64'h0);
        end
        t_gnt[0] = 1'b1;
        step();
        chk("stall_rel_gnt1", 64'(last_gnt[0]), 64'h2);
        chk("stall_rel_addr", 64'(last_addr[0]), 64'h155);
        t_req[0][1] = 1'b0;
        step();
        chk("stall_rel_gnt0", 64'(last_gnt[0]), 64'h1);

        // Writes; wrap-around on the 3-input instance.
        clr();
        t_req[0][3] = 1'b1; t_wen[0][3] = 1'b1;
        t_req[1][2] = 1'b1; t_wen[1][2] = 1'b1;
        step();
        chk("wr_gnt_a", 64'(last_gnt[0]), 64'h8);
        chk("wrap_gnt_b2", 64'(last_gnt[1]), 64'h4);
        t_req[0][3] = 1'b0;
        t_req[1][0] = 1'b1; t_wen[1][2] = 1'b0;
        step();
        chk("wr_novld_a", 64'(last_vld[0]), 64'h0);
        chk("wr_vld_b", 64'(last_vld[1]), 64'h4);
        chk("wrap_gnt_b0", 64'(last_gnt[1]), 64'h1);
        t_req[1][0] = 1'b0;
        step();
        chk("wrap_gnt_b2b", 64'(last_gnt[1]), 64'h4);
        chk("wrap_vld_b0", 64'(last_vld[1]), 64'h1);

        // Randomized traffic with held payloads while stalled.
        for (int k = 0; k < 4; k++) begin
            held[0][k] = 1'b0;
            held[1][k] = 1'b0;
        end
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            step();
        end
        t_gnt[0] = 1'b1;
        t_gnt[1] = 1'b1;
        t_rdata[0] = data_t'($urandom);
        t_rdata[1] = data_t'($urandom);
        step();

        // Reset right after a read grant drops the pending response.
        clr();
        t_req[0][1] = 1'b1;
        t_req[1][1] = 1'b1;
        step();
        chk("pre_rst_gnt", 64'(last_gnt[0]), 64'h2);
        clr();
        rst_ni = 1'b0;
        model_reset();
        drive();
        #1;
        chk("rst_vld_a", 64'(vld_a), 64'h0);
        chk("rst_vld_b", 64'(vld_b), 64'h0);
        @(negedge clk);
        step();
        rst_ni = 1'b1;
        for (int k = 0; k < 4; k++) t_req[0][k] = 1'b1;
        for (int k = 0; k < 3; k++) t_req[1][k] = 1'b1;
        step();
        chk("rst_prio_a", 64'(last_gnt[0]), 64'h1);
        chk("rst_prio_b", 64'(last_gnt[1]), 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
